// File: rtl/fpdiv_round_pack.sv
// fpdiv_round_pack
// Final stage after the iterative binary32 divide core. Takes the unrounded
// quotient mantissa, biased exponent, sign and special-case code and produces
// the packed IEEE-754 binary32 result. Stage 1 normalizes/denormalizes and
// extracts guard/round/sticky. Stage 2 rounds, handles overflow and packs.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-low reset
//   in_valid    in   upstream holds a quotient
//   in_ready    out  transfer on in_valid && in_ready
//   in_sign     in   result sign
//   in_exp      in   [EW+1:0] signed biased exponent, before normalization
//   in_mant     in   [QW-1:0] quotient mantissa, bit QW-1 weighs 2^0
//   in_sticky   in   nonzero remainder from the divide core
//   in_special  in   [1:0] 00 normal, 01 zero, 10 inf, 11 NaN
//   round_mode  in   [1:0] 00 RNE, 01 RZ, 10 RD, 11 RU
//   out_valid   out  out_q holds a result
//   out_ready   in   transfer on out_valid && out_ready
//   out_q       out  [EW+FW:0] packed result
//   out_flags   out  [2:0] {OF,UF,NX}, only when FPDIV_FLAGS_EN is defined
//
// Build option: define FPDIV_FLAGS_EN to add out_flags. out_q is identical in
// both builds.
//
// Handshake: a side transfers on the cycle where valid && ready are both high.
// A stage advances when it is empty or its successor advances, so a full
// pipeline keeps one result per cycle and a stall holds out_q/out_valid
// stable. in_ready is forced low while reset is asserted.
`timescale 1ns/1ps
module fpdiv_round_pack #(
    parameter int EW = 8,
    parameter int FW = 23,
    parameter int QW = FW + 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sign,
    input  logic [EW+1:0]  in_exp,
    input  logic [QW-1:0]  in_mant,
    input  logic           in_sticky,
    input  logic [1:0]     in_special,
    input  logic [1:0]     round_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+FW:0] out_q
`ifdef FPDIV_FLAGS_EN
   ,output logic [2:0]     out_flags
`endif
);

    // Internal exponent is wide enough for in_exp-1 and for exponent+1.
    localparam int XW = EW + 4;
    localparam int EMAX = (1 << EW) - 1;

    localparam logic [1:0] SP_ZERO = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_NAN  = 2'd3;
    localparam logic [1:0] RM_RNE  = 2'd0;
    localparam logic [1:0] RM_RZ   = 2'd1;
    localparam logic [1:0] RM_RD   = 2'd2;
    localparam logic [1:0] RM_RU   = 2'd3;

    typedef struct packed {
        logic          sign;
        logic [1:0]    special;
        logic [1:0]    mode;
        logic [XW-1:0] exp;     // stored exponent field, 0 for subnormals
        logic          hidden;  // integer bit of the significand
        logic [FW-1:0] frac;
        logic          g;
        logic          r;
        logic          s;
`ifdef FPDIV_FLAGS_EN
        logic          tiny;
`endif
    } s1_t;

    logic           adv1, adv2;
    logic           s1_valid_q, s1_valid_d;
    s1_t            s1_q, s1_d, s1_new;
    logic           out_valid_q, out_valid_d;
    logic [EW+FW:0] out_q_q, out_q_d, result;

    logic [XW-1:0]   norm_exp, shift_raw, shamt;
    logic [QW-1:0]   norm_mant, sig_mant;
    logic [2*QW-1:0] wide;
    logic            tiny, lost;

    logic            inexact, round_up, overflow, ovf_to_inf;
    logic [FW+1:0]   sum;
    logic [XW-1:0]   rnd_exp;

`ifdef FPDIV_FLAGS_EN
    logic [2:0] out_flags_q, out_flags_d, flags;
`endif

    // Stage 1: bring the leading one to bit QW-1, then denormalize when the
    // exponent falls to zero or below. The right shift saturates at FW+3,
    // which already moves the integer bit into the sticky field.
    always_comb begin : s1_normalize
        norm_exp  = {{(XW-EW-2){in_exp[EW+1]}}, in_exp};
        norm_mant = in_mant;
        if (!in_mant[QW-1]) begin
            norm_mant = {in_mant[QW-2:0], 1'b0};
            norm_exp  = norm_exp - XW'(1);
        end
        tiny      = norm_exp[XW-1] || (norm_exp == '0);
        shift_raw = XW'(1) - norm_exp;
        shamt     = (shift_raw > XW'(FW + 3)) ? XW'(FW + 3) : shift_raw;
        // Low half of wide collects every bit shifted out of the mantissa.
        wide      = {norm_mant, {QW{1'b0}}} >> shamt;
        sig_mant  = tiny ? wide[2*QW-1:QW] : norm_mant;
        lost      = tiny && (|wide[QW-1:0]);

        s1_new         = '0;
        s1_new.sign    = in_sign;
        s1_new.special = in_special;
        s1_new.mode    = round_mode;
        s1_new.exp     = tiny ? '0 : norm_exp;
        s1_new.hidden  = sig_mant[QW-1];
        s1_new.frac    = sig_mant[QW-2 -: FW];
        s1_new.g       = sig_mant[QW-2-FW];
        s1_new.r       = sig_mant[QW-3-FW];
        s1_new.s       = (|sig_mant[QW-4-FW:0]) | lost | in_sticky;
`ifdef FPDIV_FLAGS_EN
        s1_new.tiny    = tiny;
`endif
    end

    // Stage 2: round, absorb the carry, detect overflow, pack.
    always_comb begin : s2_round
        inexact = s1_q.g | s1_q.r | s1_q.s;
        case (s1_q.mode)
            RM_RNE:  round_up = s1_q.g && (s1_q.r || s1_q.s || s1_q.frac[0]);
            RM_RZ:   round_up = 1'b0;
            RM_RD:   round_up = s1_q.sign && inexact;
            default: round_up = !s1_q.sign && inexact;
        endcase

        // A carry out of the significand leaves the fraction all zero, so
        // the low FW bits of the sum are the fraction in every case.
        sum     = {1'b0, s1_q.hidden, s1_q.frac} + (FW+2)'(round_up);
        rnd_exp = s1_q.exp;
        if (sum[FW+1]) begin
            rnd_exp = s1_q.exp + XW'(1);
        end else if (!s1_q.hidden && sum[FW]) begin
            rnd_exp = XW'(1);   // subnormal rounded up into the smallest normal
        end

        overflow   = (rnd_exp >= XW'(EMAX));
        ovf_to_inf = (s1_q.mode == RM_RNE) ||
                     (s1_q.mode == RM_RD && s1_q.sign) ||
                     (s1_q.mode == RM_RU && !s1_q.sign);

        if (overflow) begin
            result = ovf_to_inf ? {s1_q.sign, {EW{1'b1}}, {FW{1'b0}}}
                                : {s1_q.sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
        end else begin
            result = {s1_q.sign, rnd_exp[EW-1:0], sum[FW-1:0]};
        end
`ifdef FPDIV_FLAGS_EN
        flags = {overflow, s1_q.tiny && inexact, inexact || overflow};
`endif

        case (s1_q.special)
            SP_ZERO: result = {s1_q.sign, {(EW+FW){1'b0}}};
            SP_INF:  result = {s1_q.sign, {EW{1'b1}}, {FW{1'b0}}};
            SP_NAN:  result = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            default: ;
        endcase
`ifdef FPDIV_FLAGS_EN
        if (s1_q.special != 2'd0) begin
            flags = 3'b000;
        end
`endif
    end

    always_comb begin : pipe_ctrl
        adv2        = !out_valid_q || out_ready;
        adv1        = !s1_valid_q || adv2;
        in_ready    = adv1 && reset;
        s1_valid_d  = adv1 ? (in_valid && in_ready) : s1_valid_q;
        s1_d        = (adv1 && in_valid && in_ready) ? s1_new : s1_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_q_d     = (adv2 && s1_valid_q) ? result : out_q_q;
`ifdef FPDIV_FLAGS_EN
        out_flags_d = (adv2 && s1_valid_q) ? flags : out_flags_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
`ifdef FPDIV_FLAGS_EN
            out_flags_q <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
`ifdef FPDIV_FLAGS_EN
            out_flags_q <= out_flags_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
`ifdef FPDIV_FLAGS_EN
    assign out_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_fpdiv_round_pack.sv
// Testbench for fpdiv_round_pack: directed cases from the block's worked
// examples plus randomized operands checked against an arithmetic reference
// model that rounds the exact value M * 2^(E-154) to the nearest ulp.
`timescale 1ns/1ps
module tb_fpdiv_round_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic [1:0]  in_special = '0;
    logic [1:0]  round_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_q;
`ifdef FPDIV_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    fpdiv_round_pack dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_special (in_special),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q)
`ifdef FPDIV_FLAGS_EN
       ,.out_flags  (out_flags)
`endif
    );

    // ---------------- clock / ready generation ----------------
    always #5 clk = ~clk;

    logic rand_ready_en = 1'b0;
    logic ready_ctl = 1'b0;

    always @(posedge clk) begin
        #2;
        out_ready = rand_ready_en ? ($urandom_range(0, 3) != 0) : ready_ctl;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int accepted = 0;
    int received = 0;
    logic [34:0] exp_q[$];   // {flags, out_q}
    logic [31:0] t2_exp [4] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAA, 32'h3EAAAAAB};

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            logic [34:0] e;
            chk("out_pending", 35'(exp_q.size() != 0), 35'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_q", 35'(out_q), 35'(e[31:0]));
`ifdef FPDIV_FLAGS_EN
                chk("out_flags", 35'(out_flags), 35'(e[34:32]));
`endif
            end
            received++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [34:0] ref_model(input logic s, input int e, input logic [27:0] m,
                                              input logic st, input logic [1:0] sp, input logic [1:0] rm);
        longint unsigned mm, q, r, half;
        int lead, en, eb, k, field;
        logic inexact, up, ovf, to_inf;
        logic [31:0] res;
        if (sp == 2'd1) return {3'b000, s, 31'd0};
        if (sp == 2'd2) return {3'b000, s, 8'hFF, 23'd0};
        if (sp == 2'd3) return {3'b000, 32'h7FC00000};
        lead = 27;
        for (int i = 0; i < 28; i++) if (m[i]) lead = i;
        en = e - (27 - lead);          // exponent of the normalized value
        eb = (en < 1) ? 1 : en;        // exponent that sets the ulp
        k  = eb - e + 4;               // value/ulp = M / 2^k
        if (k > 40) k = 40;
        mm   = 64'(m);
        q    = mm >> k;
        r    = mm & ((64'd1 << k) - 64'd1);
        half = 64'd1 << (k - 1);
        inexact = (r != 0) || st;
        case (rm)
            2'd0:    up = (r > half) || ((r == half) && (st || q[0]));
            2'd1:    up = 1'b0;
            2'd2:    up = s && inexact;
            default: up = !s && inexact;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            eb++;
        end
        if (q >= (64'd1 << 23)) begin
            field = eb;
            q = q - (64'd1 << 23);
        end else begin
            field = 0;
        end
        ovf    = (field >= 255);
        to_inf = (rm == 2'd0) || (rm == 2'd2 && s) || (rm == 2'd3 && !s);
        if (ovf) res = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
        else     res = {s, 8'(field), q[22:0]};
        return {ovf, (en <= 0) && inexact, inexact || ovf, res};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input int e, input logic [27:0] m,
                         input logic st, input logic [1:0] sp, input logic [1:0] rm);
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = 10'(e);
        in_mant    = m;
        in_sticky  = st;
        in_special = sp;
        round_mode = rm;
    endtask

    // Called at posedge+1 with inputs driven; returns at posedge+1 after accept.
    task automatic send(input logic [34:0] expv);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 35'(in_ready), 35'd1);
        if (in_ready) begin
            exp_q.push_back(expv);
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic s, input int e, input logic [27:0] m,
                              input logic st, input logic [1:0] sp, input logic [1:0] rm);
        drive(s, e, m, st, sp, rm);
        send(ref_model(s, e, m, st, sp, rm));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 35'(exp_q.size()), 35'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc0, rcv0, e;
        logic [27:0] m;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 35'(out_valid), 35'd0);
        chk("rst_out_q", 35'(out_q), 35'd0);
        chk("rst_in_ready", 35'(in_ready), 35'd0);
`ifdef FPDIV_FLAGS_EN
        chk("rst_flags", 35'(out_flags), 35'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        ready_ctl = 1'b1;
        @(posedge clk); #1;

        // 1.5 * 2^0, exact, with latency check
        drive(1'b0, 127, 28'hC000000, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        chk("t1_in_ready", 35'(in_ready), 35'd1);
        exp_q.push_back({3'b000, 32'h3FC00000});
        accepted++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat1", 35'(out_valid), 35'd0);
        @(negedge clk);
        chk("t1_lat2", 35'(out_valid), 35'd1);
        @(posedge clk); #1;

        // 1/3 = 0.1010..b * 2^-1 with remainder, all four modes
        for (int rm = 0; rm < 4; rm++) begin
            drive(1'b0, 126, 28'h5555555, 1'b1, 2'd0, 2'(rm));
            send({3'b001, t2_exp[rm]});
        end

        // overflow
        drive(1'b0, 300, 28'h8000000, 1'b0, 2'd0, 2'd0); send({3'b101, 32'h7F800000});
        drive(1'b0, 300, 28'h8000000, 1'b0, 2'd0, 2'd1); send({3'b101, 32'h7F7FFFFF});
        drive(1'b1, 300, 28'h8000000, 1'b0, 2'd0, 2'd3); send({3'b101, 32'hFF7FFFFF});
        drive(1'b1, 300, 28'h8000000, 1'b0, 2'd0, 2'd2); send({3'b101, 32'hFF800000});
        drive(1'b0, 300, 28'h8000000, 1'b0, 2'd0, 2'd3); send({3'b101, 32'h7F800000});

        // subnormals
        drive(1'b0, -22, 28'h8000000, 1'b0, 2'd0, 2'd0); send({3'b000, 32'h00000001});
        drive(1'b0, 0, 28'hFFFFFFF, 1'b0, 2'd0, 2'd0);   send({3'b011, 32'h00800000});
        wait_drain();

        // back-pressure: two accepted, third held off
        acc0 = accepted;
        rcv0 = received;
        ready_ctl = 1'b0;
        send_model(1'b0, 130, 28'hA123456, 1'b0, 2'd0, 2'd0);
        send_model(1'b1, 120, 28'h6543210, 1'b1, 2'd0, 2'd1);
        drive(1'b0, 140, 28'hFFFFFF8, 1'b1, 2'd0, 2'd3);
        @(negedge clk);
        chk("t5_in_ready_low", 35'(in_ready), 35'd0);
        chk("t5_accepted", 35'(accepted - acc0), 35'd2);
        chk("t5_hold_valid", 35'(out_valid), 35'd1);
        chk("t5_hold_q", 35'(out_q), 35'(exp_q[0][31:0]));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_hold_q2", 35'(out_q), 35'(exp_q[0][31:0]));
        @(posedge clk); #1;
        ready_ctl = 1'b1;
        send(ref_model(1'b0, 140, 28'hFFFFFF8, 1'b1, 2'd0, 2'd3));
        wait_drain();
        chk("t5_received", 35'(received - rcv0), 35'd3);

        // reset with two results in flight
        ready_ctl = 1'b0;
        send_model(1'b0, 100, 28'h9000000, 1'b0, 2'd0, 2'd0);
        send_model(1'b1, 110, 28'h7000000, 1'b0, 2'd0, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_in_ready", 35'(in_ready), 35'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_out_valid", 35'(out_valid), 35'd0);
        chk("t6_out_q", 35'(out_q), 35'd0);
        accepted = accepted - exp_q.size();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        ready_ctl = 1'b1;
        drive(1'b1, 0, 28'h8000000, 1'b0, 2'd3, 2'd0); send({3'b000, 32'h7FC00000});
        drive(1'b1, 0, 28'h8000000, 1'b0, 2'd2, 2'd0); send({3'b000, 32'hFF800000});
        drive(1'b1, 0, 28'h8000000, 1'b0, 2'd1, 2'd2); send({3'b000, 32'h80000000});
        drive(1'b0, 127, 28'hC000000, 1'b0, 2'd0, 2'd0); send({3'b000, 32'h3FC00000});

        // randomized traffic with random back-pressure
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       e = int'($urandom_range(0, 35)) - 30;
                1:       e = int'($urandom_range(248, 262));
                default: e = int'($urandom_range(1, 254));
            endcase
            if ($urandom_range(0, 1) == 1) m = {1'b1, 27'($urandom)};
            else                           m = {2'b01, 26'($urandom)};
            if ($urandom_range(0, 7) == 0) m[26:3] = '1;
            send_model(1'($urandom_range(0, 1)), e, m, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                       2'($urandom_range(0, 3)));
        end
        rand_ready_en = 1'b0;
        ready_ctl = 1'b1;
        wait_drain();
        chk("io_count", 35'(received), 35'(accepted));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
